data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 154 +++++++++++++++
 tb/tb_data_mem_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Fixed-latency 16-bit data memory responder: one request in flight, response strobe LATENCY
// cycles after acceptance, out-of-range addresses flagged with rsp_err.
module data_mem_responder #(
   parameter int unsigned LATENCY = 4,
   parameter int unsigned AW      = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_wr,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned DW    = 16;
   localparam int unsigned HW    = 15;
   localparam int unsigned CW    = 4;
   localparam int unsigned DEPTH = 1 << AW;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            wr_q, wr_d;
   logic [HW-1:0]   haddr_q, haddr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [DW-1:0]   hold_q, hold_d;
   logic            herr_q, herr_d;
   logic            ready_q, ready_d;
   logic            valid_q, valid_d;
   logic            err_q, err_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic [DW-1:0]   mem_q [DEPTH];

   logic            op_wr_c;
   logic [HW-1:0]   op_haddr_c;
   logic [DW-1:0]   op_wdata_c;
   logic [AW-1:0]   idx_c;
   logic            oor_c;
   logic            enter_resp_c;
   logic            we_c;
   logic            unused_c;

   assign unused_c = req_addr[0];

   // With LATENCY=1 the operation completes on the acceptance edge, so it must use the live inputs.
   always_comb begin
      op_wr_c    = (state_q == IDLE) ? req_wr          : wr_q;
      op_haddr_c = (state_q == IDLE) ? req_addr[15:1]  : haddr_q;
      op_wdata_c = (state_q == IDLE) ? req_wdata       : wdata_q;
      idx_c      = op_haddr_c[AW-1:0];
      oor_c      = (op_haddr_c >> AW) != HW'(0);
   end

   // Next-state, capture and response staging.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      wr_d         = wr_q;
      haddr_d      = haddr_q;
      wdata_d      = wdata_q;
      hold_d       = hold_q;
      herr_d       = herr_q;
      enter_resp_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               wr_d    = req_wr;
               haddr_d = req_addr[15:1];
               wdata_d = req_wdata;
               if (LATENCY == 1) begin
                  state_d      = RESP;
                  enter_resp_c = 1'b1;
               end else begin
                  state_d = BUSY;
                  cnt_d   = CW'(LATENCY - 1);
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d      = RESP;
               enter_resp_c = 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      we_c = enter_resp_c & op_wr_c & ~oor_c;
      if (enter_resp_c) begin
         hold_d = (op_wr_c || oor_c) ? DW'(0) : mem_q[idx_c];
         herr_d = oor_c;
      end

      // Response is presented the cycle after RESP so the strobe lands exactly LATENCY edges out.
      ready_d = (state_d == IDLE);
      valid_d = (state_q == RESP);
      rdata_d = valid_d ? hold_q : DW'(0);
      err_d   = valid_d & herr_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         haddr_q <= '0;
         wdata_q <= '0;
         hold_q  <= '0;
         herr_q  <= 1'b0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         haddr_q <= haddr_d;
         wdata_q <= wdata_d;
         hold_q  <= hold_d;
         herr_q  <= herr_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Storage, cleared on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else if (we_c) begin
         mem_q[idx_c] <= op_wdata_c;
      end
   end

   assign req_ready = ready_q;
   assign rsp_valid = valid_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: directed table, reset/throughput sequences, random traffic vs memory model.
module tb_data_mem_responder;

   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_wr = 1'b0;
   logic [15:0] req_addr = '0, req_wdata = '0;
   logic        req_ready, rsp_valid, rsp_err;
   logic [15:0] rsp_rdata;

   logic        q_valid = 1'b0, q_wr = 1'b0;
   logic [15:0] q_addr = '0, q_wdata = '0;
   logic        q_ready, q_rvalid, q_err;
   logic [15:0] q_rdata;

   int n_tests = 0;
   int n_fail  = 0;
   logic [15:0] model [256];

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_rd;
      logic        exp_err;
   } vec_t;
   vec_t tbl [12];

   always #5 clk = ~clk;

   data_mem_responder #(.LATENCY(LAT), .AW(8)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   data_mem_responder #(.LATENCY(1), .AW(8)) dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(q_valid), .req_wr(q_wr),
      .req_addr(q_addr), .req_wdata(q_wdata), .req_ready(q_ready),
      .rsp_valid(q_rvalid), .rsp_rdata(q_rdata), .rsp_err(q_err)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic is_oor(input logic [15:0] a);
      return a >= 16'h0200;
   endfunction

   // One request on the LATENCY=4 instance; garbage is driven on the inputs while it is pending.
   task automatic xact(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                       input logic [15:0] exp_rd, input logic exp_err, input string nm);
      int cyc;
      chk({nm, " ready_before"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd;
      @(negedge clk);
      cyc = 0;
      while (!rsp_valid && cyc < 20) begin
         chk({nm, " ready_busy"}, 32'(req_ready), 32'd0);
         chk({nm, " idle_outputs"}, 32'({rsp_rdata, rsp_err}), 32'd0);
         req_valid = 1'($urandom_range(0, 1));
         req_wr    = 1'($urandom_range(0, 1));
         req_addr  = 16'($urandom);
         req_wdata = 16'($urandom);
         @(negedge clk);
         cyc++;
      end
      req_valid = 1'b0;
      chk({nm, " latency"}, 32'(cyc), 32'(LAT));
      chk({nm, " rdata"}, 32'(rsp_rdata), 32'(exp_rd));
      chk({nm, " err"}, 32'(rsp_err), 32'(exp_err));
      chk({nm, " ready_after"}, 32'(req_ready), 32'd1);
      if (wr && !is_oor(addr)) model[int'(addr >> 1)] = wd;
   endtask

   task automatic rand_xact(input int k);
      logic        wr;
      logic [15:0] a, d, e;
      wr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
         0:       a = 16'($urandom_range(16'h0200, 16'hFFFF));
         1, 2:    a = 16'($urandom_range(0, 16'h001F));
         default: a = 16'($urandom_range(0, 16'h01FF));
      endcase
      d = 16'($urandom);
      e = (wr || is_oor(a)) ? 16'h0000 : model[int'(a >> 1)];
      xact(wr, a, d, e, is_oor(a), $sformatf("rand%0d", k));
   endtask

   // One request on the LATENCY=1 instance.
   task automatic xact1(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                        input logic [15:0] exp_rd, input logic exp_err, input string nm);
      chk({nm, " ready_before"}, 32'(q_ready), 32'd1);
      q_valid = 1'b1; q_wr = wr; q_addr = addr; q_wdata = wd;
      @(negedge clk);
      chk({nm, " ready_busy"}, 32'(q_ready), 32'd0);
      chk({nm, " early_valid"}, 32'(q_rvalid), 32'd0);
      q_valid = 1'b1; q_wr = 1'b1; q_addr = 16'h0006; q_wdata = 16'hDEAD;
      @(negedge clk);
      q_valid = 1'b0;
      chk({nm, " valid"}, 32'(q_rvalid), 32'd1);
      chk({nm, " rdata"}, 32'(q_rdata), 32'(exp_rd));
      chk({nm, " err"}, 32'(q_err), 32'(exp_err));
      chk({nm, " ready_after"}, 32'(q_ready), 32'd1);
   endtask

   initial begin
      int last, acc, w;

      tbl[0]  = '{1'b0, 16'h0010, 16'h0000, 16'h0000, 1'b0};
      tbl[1]  = '{1'b1, 16'h0020, 16'hBEEF, 16'h0000, 1'b0};
      tbl[2]  = '{1'b0, 16'h0021, 16'h0000, 16'hBEEF, 1'b0};
      tbl[3]  = '{1'b1, 16'h0200, 16'h1234, 16'h0000, 1'b1};
      tbl[4]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0};
      tbl[5]  = '{1'b0, 16'h01FE, 16'h0000, 16'h0000, 1'b0};
      tbl[6]  = '{1'b1, 16'h01FE, 16'h5A5A, 16'h0000, 1'b0};
      tbl[7]  = '{1'b0, 16'h01FF, 16'h0000, 16'h5A5A, 1'b0};
      tbl[8]  = '{1'b0, 16'hFFFE, 16'h0000, 16'h0000, 1'b1};
      tbl[9]  = '{1'b1, 16'h0004, 16'h1111, 16'h0000, 1'b0};
      tbl[10] = '{1'b0, 16'h0004, 16'h0000, 16'h1111, 1'b0};
      tbl[11] = '{1'b0, 16'h0020, 16'h0000, 16'hBEEF, 1'b0};
      for (int i = 0; i < 256; i++) model[i] = 16'h0000;

      repeat (2) @(negedge clk);
      chk("reset ready", 32'(req_ready), 32'd1);
      chk("reset outputs", 32'({rsp_valid, rsp_rdata, rsp_err}), 32'd0);
      chk("reset ready l1", 32'(q_ready), 32'd1);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++)
         xact(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_err,
              $sformatf("vec%0d", i));

      // Continuous requests: acceptances spaced exactly LAT+1 cycles, strobe coincides with ready.
      last = -1; acc = 0;
      req_valid = 1'b1; req_wr = 1'b0;
      for (int c = 0; c < 21; c++) begin
         if (c > 0) chk("thru valid_vs_ready", 32'(rsp_valid), 32'(req_ready));
         if (req_ready) begin
            if (last >= 0) chk("thru gap", 32'(c - last), 32'(LAT + 1));
            last = c;
            acc++;
         end
         req_addr = c[0] ? 16'h0012 : 16'h0010;
         @(negedge clk);
      end
      req_valid = 1'b0;
      chk("thru count", 32'(acc), 32'd5);
      w = 0;
      while (!req_ready && w < 20) begin @(negedge clk); w++; end
      chk("thru drain", 32'(req_ready), 32'd1);

      // Reset while a write is pending: the write must never land.
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0004; req_wdata = 16'hAAAA;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("abort pending_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("abort reset_ready", 32'(req_ready), 32'd1);
      chk("abort reset_outputs", 32'({rsp_valid, rsp_rdata, rsp_err}), 32'd0);
      @(negedge clk);
      chk("abort reset_outputs2", 32'({rsp_valid, rsp_rdata, rsp_err}), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 256; i++) model[i] = 16'h0000;
      xact(1'b0, 16'h0004, 16'h0000, 16'h0000, 1'b0, "abort read");
      xact(1'b0, 16'h0020, 16'h0000, 16'h0000, 1'b0, "abort cleared");

      xact1(1'b1, 16'h0006, 16'hCAFE, 16'h0000, 1'b0, "l1 wr");
      xact1(1'b0, 16'h0007, 16'h0000, 16'hCAFE, 1'b0, "l1 rd");
      xact1(1'b0, 16'h0400, 16'h0000, 16'h0000, 1'b1, "l1 oor");

      for (int k = 0; k < 60; k++) rand_xact(k);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
